ram_arbiter: RTL

- Shares the single RAM port among the instruction and data caches of CPUS cores; sits between the cache layer and RAM.
- Registered grant with a small FSM.
- Priority: dcache over icache, round-robin across cores.
- Holds ownership for multi-word block transfers while the owner asserts dlock.

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/ram_arbiter_rr_pick.sv | 27 ++
 rtl/ram_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types plus the arbiter FSM encoding and default requester count.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  localparam int CPUS_DEFAULT = 2;
  localparam int ARB_REQS     = 2 * CPUS_DEFAULT;
endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          valid
);
  logic [PW:0] sum;

  // Scan offsets from far to near so the nearest hit is the last assignment.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (PW + 1)'(k);
      if (sum >= (PW + 1)'(N)) sum = sum - (PW + 1)'(N);
      if (req[sum[PW-1:0]]) begin
        idx   = sum[PW-1:0];
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter for CPUS cores (icache + dcache each), dcache first, round-robin by core.
// Optional starvation override enabled by defining ARB_ANTISTARVE_EN.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS         = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [CPUS-1:0]             iREN,
  input  word_t [CPUS-1:0]            iaddr,
  output logic [CPUS-1:0]             iwait,
  output word_t [CPUS-1:0]            iload,
  input  logic [CPUS-1:0]             dREN,
  input  logic [CPUS-1:0]             dWEN,
  input  logic [CPUS-1:0]             dlock,
  input  word_t [CPUS-1:0]            daddr,
  input  word_t [CPUS-1:0]            dstore,
  output logic [CPUS-1:0]             dwait,
  output word_t [CPUS-1:0]            dload,
  output logic                        ramREN,
  output logic                        ramWEN,
  output word_t                       ramaddr,
  output word_t                       ramstore,
  input  word_t                       ramload,
  input  ramstate_t                   ramstate,
  output logic                        gnt_valid,
  output logic [$clog2(2*CPUS)-1:0]   gnt_id,
  output logic                        err
);
  localparam int REQS = 2 * CPUS;
  localparam int IDW  = $clog2(REQS);
  localparam int CW   = (CPUS > 1) ? $clog2(CPUS) : 1;

  arb_state_t      state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [CW-1:0]   rr_q, rr_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic            err_q, err_d;

  logic [CPUS-1:0] dreq;
  logic [CW-1:0]   d_idx, i_idx;
  logic            d_valid, i_valid;
  logic [IDW-1:0]  class_id, win_id;
  logic            class_valid, win_valid;

  logic [CW-1:0]   own_core;
  logic            own_is_d, own_req, done;

  assign dreq = dREN | dWEN;

  genvar gi;
  generate
    for (gi = 0; gi < CPUS; gi++) begin : g_load
      assign iload[gi] = ramload;
      assign dload[gi] = ramload;
    end
  endgenerate

  rr_pick #(.N(CPUS), .PW(CW)) u_pick_d (
    .req   (dreq),
    .ptr   (rr_q),
    .idx   (d_idx),
    .valid (d_valid)
  );

  rr_pick #(.N(CPUS), .PW(CW)) u_pick_i (
    .req   (iREN),
    .ptr   (rr_q),
    .idx   (i_idx),
    .valid (i_valid)
  );

  always_comb begin
    class_id    = '0;
    class_valid = 1'b0;
    if (d_valid) begin
      class_id    = IDW'(int'(d_idx) * 2 + 1);
      class_valid = 1'b1;
    end else if (i_valid) begin
      class_id    = IDW'(int'(i_idx) * 2);
      class_valid = 1'b1;
    end
  end

`ifdef ARB_ANTISTARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [REQS-1:0] req_flat;
  logic [REQS-1:0] starved;
  logic [IDW-1:0]  starve_id;
  logic            starve_valid;

  generate
    for (gi = 0; gi < CPUS; gi++) begin : g_flat
      assign req_flat[2*gi]     = iREN[gi];
      assign req_flat[2*gi + 1] = dreq[gi];
    end

    for (gi = 0; gi < REQS; gi++) begin : g_starve
      logic [SW-1:0] cnt_q, cnt_d;
      logic          is_own, granted;

      assign is_own  = (state_q == OWN) && (owner_q == IDW'(gi));
      assign granted = (state_q == IDLE) && win_valid && (win_id == IDW'(gi));

      always_comb begin
        cnt_d = cnt_q;
        if (!req_flat[gi] || granted) cnt_d = '0;
        else if (!is_own && (cnt_q != SW'(STARVE_LIMIT))) cnt_d = cnt_q + SW'(1);
      end

      always_ff @(posedge CLK) begin
        if (!nRST) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end

      assign starved[gi] = req_flat[gi] && (cnt_q == SW'(STARVE_LIMIT));
    end
  endgenerate

  // Lowest starved index wins outright, ahead of class priority.
  always_comb begin
    starve_id    = '0;
    starve_valid = 1'b0;
    for (int k = REQS - 1; k >= 0; k--) begin
      if (starved[k]) begin
        starve_id    = IDW'(k);
        starve_valid = 1'b1;
      end
    end
  end

  assign win_id    = starve_valid ? starve_id : class_id;
  assign win_valid = starve_valid | class_valid;
`else
  assign win_id    = class_id;
  assign win_valid = class_valid;
`endif

  assign own_core = CW'(owner_q >> 1);
  assign own_is_d = owner_q[0];
  assign own_req  = own_is_d ? dreq[own_core] : iREN[own_core];
  assign done     = (ramstate == ACCESS) || (ramstate == ERROR);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_q        <= '0;
      gnt_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      gnt_valid_q <= gnt_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = OWN;
          owner_d = win_id;
        end
      end
      OWN: begin
        if (!own_req) begin
          state_d = IDLE;
        end else if (done) begin
          if (ramstate == ERROR) err_d = 1'b1;
          // A locked dcache burst keeps the bus without an IDLE gap.
          if (!(own_is_d && dlock[own_core])) begin
            state_d = IDLE;
            rr_d    = (int'(own_core) == CPUS - 1) ? '0 : own_core + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_valid_d = (state_d == OWN);
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    if (state_q == OWN && own_req) begin
      if (own_is_d) begin
        ramWEN   = dWEN[own_core];
        ramREN   = dREN[own_core] & ~dWEN[own_core];
        ramaddr  = daddr[own_core];
        ramstore = dstore[own_core];
        if (done) dwait[own_core] = 1'b0;
      end else begin
        ramREN  = 1'b1;
        ramaddr = iaddr[own_core];
        if (done) iwait[own_core] = 1'b0;
      end
    end
  end

  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = owner_q;
  assign err       = err_q;
endmodule
